// File: rtl/io_wr_arbiter_if.sv
// io_wr_arbiter_if: one store-request channel (valid/ready plus payload) into the
// peripheral write arbiter. Requesters use the master modport, the arbiter the slave.
`default_nettype none

interface io_wr_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] data;
  logic [2:0]  funct3;

  modport master (output valid, output addr, output data, output funct3, input ready);
  modport slave  (input valid, input addr, input data, input funct3, output ready);
endinterface

`default_nettype wire

// File: rtl/io_wr_arbiter.sv
// io_wr_arbiter: two-requester arbiter feeding a registered write pulse to the output
// peripherals. Optional address checker: define IO_ARB_ADDR_CHECK_EN.
`default_nettype none

module io_wr_arbiter #(
  parameter int M0_PRIO      = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  io_wr_arbiter_if.slave  m0,
  io_wr_arbiter_if.slave  m1,
  output logic            o_io_wren,
  output logic [31:0]     o_io_addr,
  output logic [31:0]     o_io_st_data,
  output logic [2:0]      o_io_funct3,
  output logic            o_grant_id,
  output logic            o_err,
  output logic            o_err_id,
  output logic [7:0]      o_err_cnt
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic        w_m0_rdy;
  logic        w_m1_rdy;
  logic        w_xfer;
  logic        w_sel;
  logic        w_fwd;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [2:0]  w_f3;
  logic        r_last_grant;
  logic [7:0]  r_starve_cnt;

  // A lone valid always wins; contention is resolved by policy.
  always_comb begin
    w_m0_rdy = m0.valid;
    w_m1_rdy = m1.valid;
    if (m0.valid && m1.valid) begin
      if (M0_PRIO != 0) begin
        w_m1_rdy = (r_starve_cnt == STARVE_MAX);
      end else begin
        w_m1_rdy = ~r_last_grant;
      end
      w_m0_rdy = ~w_m1_rdy;
    end
  end

  assign m0.ready = w_m0_rdy;
  assign m1.ready = w_m1_rdy;
  assign w_xfer   = w_m0_rdy | w_m1_rdy;
  assign w_sel    = w_m1_rdy;
  assign w_addr   = w_sel ? m1.addr   : m0.addr;
  assign w_data   = w_sel ? m1.data   : m0.data;
  assign w_f3     = w_sel ? m1.funct3 : m0.funct3;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_last_grant <= 1'b1;
      r_starve_cnt <= 8'd0;
    end else begin
      if (w_xfer) begin
        r_last_grant <= w_sel;
      end
      if ((M0_PRIO == 0) || !m1.valid || w_m1_rdy) begin
        r_starve_cnt <= 8'd0;
      end else if (r_starve_cnt != STARVE_MAX) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end

`ifdef IO_ARB_ADDR_CHECK_EN
  logic       w_bad;
  logic       r_err;
  logic       r_err_id;
  logic [7:0] r_err_cnt;

  // Peripheral window is 0x1000_0000..0x1000_4FFF, byte/half/word stores only.
  assign w_bad = (w_addr[31:16] != 16'h1000) || (w_addr[15:12] > 4'd4) || (w_f3 > 3'd2);
  assign w_fwd = w_xfer & ~w_bad;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_err     <= 1'b0;
      r_err_id  <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_err <= w_xfer & w_bad;
      if (w_xfer && w_bad) begin
        r_err_id <= w_sel;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  assign o_err     = r_err;
  assign o_err_id  = r_err_id;
  assign o_err_cnt = r_err_cnt;
`else
  assign w_fwd     = w_xfer;
  assign o_err     = 1'b0;
  assign o_err_id  = 1'b0;
  assign o_err_cnt = 8'd0;
`endif

  // Output registers only move on a forwarded store, so drops leave them intact.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_io_wren    <= 1'b0;
      o_io_addr    <= 32'd0;
      o_io_st_data <= 32'd0;
      o_io_funct3  <= 3'd0;
      o_grant_id   <= 1'b0;
    end else begin
      o_io_wren <= w_fwd;
      if (w_fwd) begin
        o_io_addr    <= w_addr;
        o_io_st_data <= w_data;
        o_io_funct3  <= w_f3;
        o_grant_id   <= w_sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_io_wr_arbiter.sv
// tb_io_wr_arbiter: scoreboard bench; a round-robin and a fixed-priority instance
// share clock and reset, stimulus pushes expected outputs, monitors pop and compare.
`default_nettype none

module tb_io_wr_arbiter;

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic        id;
    logic [7:0]  cnt;
  } exp_t;

  logic clk;
  logic i_reset;
  int   checks;
  int   errors;
  exp_t q_rr[$];
  exp_t q_fp[$];

  io_wr_arbiter_if rr_m0 ();
  io_wr_arbiter_if rr_m1 ();
  io_wr_arbiter_if fp_m0 ();
  io_wr_arbiter_if fp_m1 ();

  logic        rr_wren, rr_gid, rr_err, rr_err_id;
  logic [31:0] rr_addr, rr_data;
  logic [2:0]  rr_f3;
  logic [7:0]  rr_err_cnt;
  logic        fp_wren, fp_gid, fp_err, fp_err_id;
  logic [31:0] fp_addr, fp_data;
  logic [2:0]  fp_f3;
  logic [7:0]  fp_err_cnt;

  io_wr_arbiter #(.M0_PRIO(0), .STARVE_LIMIT(4)) u_rr (
    .i_clk(clk), .i_reset(i_reset), .m0(rr_m0), .m1(rr_m1),
    .o_io_wren(rr_wren), .o_io_addr(rr_addr), .o_io_st_data(rr_data),
    .o_io_funct3(rr_f3), .o_grant_id(rr_gid), .o_err(rr_err),
    .o_err_id(rr_err_id), .o_err_cnt(rr_err_cnt)
  );

  io_wr_arbiter #(.M0_PRIO(1), .STARVE_LIMIT(4)) u_fp (
    .i_clk(clk), .i_reset(i_reset), .m0(fp_m0), .m1(fp_m1),
    .o_io_wren(fp_wren), .o_io_addr(fp_addr), .o_io_st_data(fp_data),
    .o_io_funct3(fp_f3), .o_grant_id(fp_gid), .o_err(fp_err),
    .o_err_id(fp_err_id), .o_err_cnt(fp_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t wr(input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] f, input logic id);
    exp_t e;
    e = '{err: 1'b0, addr: a, data: d, f3: f, id: id, cnt: 8'd0};
    return e;
  endfunction

  function automatic exp_t drop(input logic id, input logic [7:0] cnt);
    exp_t e;
    e = '{err: 1'b1, addr: 32'd0, data: 32'd0, f3: 3'd0, id: id, cnt: cnt};
    return e;
  endfunction

  always @(negedge clk) begin : mon_rr
    exp_t e;
    if (i_reset && (rr_wren || rr_err)) begin
      if (q_rr.size() == 0) begin
        chk("rr_unexpected_pulse", {94'd0, rr_wren, rr_err}, 96'd0);
      end else begin
        e = q_rr.pop_front();
        if (e.err)
          chk("rr_drop", {rr_err, rr_wren, rr_err_id, rr_err_cnt}, {1'b1, 1'b0, e.id, e.cnt});
        else
          chk("rr_write", {rr_wren, rr_err, rr_addr, rr_data, rr_f3, rr_gid},
              {1'b1, 1'b0, e.addr, e.data, e.f3, e.id});
      end
    end
  end

  always @(negedge clk) begin : mon_fp
    exp_t e;
    if (i_reset && (fp_wren || fp_err)) begin
      if (q_fp.size() == 0) begin
        chk("fp_unexpected_pulse", {94'd0, fp_wren, fp_err}, 96'd0);
      end else begin
        e = q_fp.pop_front();
        if (e.err)
          chk("fp_drop", {fp_err, fp_wren, fp_err_id, fp_err_cnt}, {1'b1, 1'b0, e.id, e.cnt});
        else
          chk("fp_write", {fp_wren, fp_err, fp_addr, fp_data, fp_f3, fp_gid},
              {1'b1, 1'b0, e.addr, e.data, e.f3, e.id});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   n0;
    int   n1;
    logic id;
    checks  = 0;
    errors  = 0;
    i_reset = 1'b0;
    {rr_m0.valid, rr_m1.valid, fp_m0.valid, fp_m1.valid} = 4'b0;
    rr_m0.addr = 32'd0; rr_m0.data = 32'd0; rr_m0.funct3 = 3'd0;
    rr_m1.addr = 32'd0; rr_m1.data = 32'd0; rr_m1.funct3 = 3'd0;
    fp_m0.addr = 32'd0; fp_m0.data = 32'd0; fp_m0.funct3 = 3'd0;
    fp_m1.addr = 32'd0; fp_m1.data = 32'd0; fp_m1.funct3 = 3'd0;

    @(negedge clk);
    chk("reset_outputs", {rr_wren, rr_addr, rr_data, rr_f3, rr_gid, rr_err, rr_err_id, rr_err_cnt},
        96'd0);
    chk("reset_ready", {94'd0, rr_m0.ready, rr_m1.ready}, 96'd0);
    step();
    i_reset = 1'b1;
    step();

    // Round-robin with both requesters saturating: 0,1,0,1,0,1.
    n0 = 0; n1 = 0;
    for (int i = 0; i < 6; i++) begin
      id = 1'(i % 2);
      rr_m0.valid = 1'b1; rr_m0.addr = 32'h1000_0000; rr_m0.funct3 = 3'd2;
      rr_m0.data  = 32'hA000_0000 + 32'(n0);
      rr_m1.valid = 1'b1; rr_m1.addr = 32'h1000_4004; rr_m1.funct3 = 3'd1;
      rr_m1.data  = 32'hB000_0000 + 32'(n1);
      #1;
      chk("rr_grant", {94'd0, rr_m0.ready, rr_m1.ready}, {94'd0, ~id, id});
      if (id) q_rr.push_back(wr(32'h1000_4004, 32'hB000_0000 + 32'(n1), 3'd1, 1'b1));
      else    q_rr.push_back(wr(32'h1000_0000, 32'hA000_0000 + 32'(n0), 3'd2, 1'b0));
      step();
      if (id) n1++; else n0++;
    end
    rr_m0.valid = 1'b0; rr_m1.valid = 1'b0;

    // Single SW from requester 0, granted in the same cycle.
    rr_m0.valid = 1'b1; rr_m0.addr = 32'h1000_1000; rr_m0.data = 32'hDEAD_BEEF; rr_m0.funct3 = 3'd2;
    #1;
    chk("single_ready", {94'd0, rr_m0.ready, rr_m1.ready}, {94'd0, 2'b10});
    q_rr.push_back(wr(32'h1000_1000, 32'hDEAD_BEEF, 3'd2, 1'b0));
    step();
    rr_m0.valid = 1'b0;
    step();

    // SB outside the peripheral window from requester 1.
    rr_m1.valid = 1'b1; rr_m1.addr = 32'h2000_0000; rr_m1.data = 32'h0000_00A5; rr_m1.funct3 = 3'd0;
    #1;
    chk("oow_ready", {94'd0, rr_m0.ready, rr_m1.ready}, {94'd0, 2'b01});
`ifdef IO_ARB_ADDR_CHECK_EN
    q_rr.push_back(drop(1'b1, 8'd1));
    step();
    rr_m1.addr = 32'h1000_2000; rr_m1.funct3 = 3'b011;
    q_rr.push_back(drop(1'b1, 8'd2));
    step();
    rr_m1.valid = 1'b0;
    rr_m0.valid = 1'b1; rr_m0.addr = 32'h1000_5000; rr_m0.funct3 = 3'd2;
    for (int i = 0; i < 300; i++) begin
      rr_m0.data = 32'(i);
      q_rr.push_back(drop(1'b0, (i + 3 > 255) ? 8'd255 : 8'(i + 3)));
      step();
    end
    rr_m0.valid = 1'b0;
    @(negedge clk);
    chk("drop_holds_regs", {rr_addr, rr_data, 32'd0}, {32'h1000_1000, 32'hDEAD_BEEF, 32'd0});
    chk("err_cnt_sat", {88'd0, rr_err_cnt}, {88'd0, 8'd255});
`else
    q_rr.push_back(wr(32'h2000_0000, 32'h0000_00A5, 3'd0, 1'b1));
    step();
    rr_m1.valid = 1'b0;
    @(negedge clk);
    chk("no_check_err_cnt", {87'd0, rr_err, rr_err_cnt}, 96'd0);
`endif
    step();

    // Fixed priority with STARVE_LIMIT=4: 0,0,0,0,1 repeating.
    n0 = 0; n1 = 0;
    for (int i = 0; i < 10; i++) begin
      id = (i % 5 == 4);
      fp_m0.valid = 1'b1; fp_m0.addr = 32'h1000_0010; fp_m0.funct3 = 3'd2;
      fp_m0.data  = 32'hC000_0000 + 32'(n0);
      fp_m1.valid = 1'b1; fp_m1.addr = 32'h1000_3020; fp_m1.funct3 = 3'd0;
      fp_m1.data  = 32'hD000_0000 + 32'(n1);
      #1;
      chk("fp_grant", {94'd0, fp_m0.ready, fp_m1.ready}, {94'd0, ~id, id});
      if (id) q_fp.push_back(wr(32'h1000_3020, 32'hD000_0000 + 32'(n1), 3'd0, 1'b1));
      else    q_fp.push_back(wr(32'h1000_0010, 32'hC000_0000 + 32'(n0), 3'd2, 1'b0));
      step();
      if (id) n1++; else n0++;
    end
    fp_m0.valid = 1'b0; fp_m1.valid = 1'b0;
    step();

    // Reset right after a transfer: the pending pulse must vanish.
    rr_m0.valid = 1'b1; rr_m0.addr = 32'h1000_0444; rr_m0.data = 32'h1234_5678; rr_m0.funct3 = 3'd2;
    step();
    rr_m0.valid = 1'b0;
    i_reset = 1'b0;
    @(negedge clk);
    chk("reset_midop", {rr_wren, rr_addr, rr_data, rr_err_cnt, 23'd0},
        {1'b0, 32'd0, 32'd0, 8'd0, 23'd0});
    step();
    i_reset = 1'b1;
    repeat (4) step();

    chk("rr_queue_drained", 96'(q_rr.size()), 96'd0);
    chk("fp_queue_drained", 96'(q_fp.size()), 96'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/io_wr_arbiter.md
# io_wr_arbiter

Two-requester arbiter and sequencer for the memory-mapped output-peripheral write port (LEDR, LEDG, HEXL, HEXH, LCD). It accepts store requests from the CPU LSU (requester 0) and a debug/UART bridge (requester 1) over valid/ready handshakes. It grants exactly one per cycle and drives a registered, single-cycle write pulse plus address/data/funct3 into the output buffer. With the optional address checker compiled in, stores that fall outside the peripheral window are dropped and flagged.

## Interface
- M0_PRIO, 0: 0 = round-robin; 1 = requester 0 fixed priority with starvation guard for requester 1.
- STARVE_LIMIT, 4: consecutive lost cycles after which requester 1 is force-granted (M0_PRIO=1 only); range 1..255.
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_m0_valid / i_m1_valid  in  1  request valid
- o_m0_ready / o_m1_ready  out  1  grant; transfer occurs when valid & ready in the same cycle
- i_m0_addr / i_m1_addr  in  32  store byte address
- i_m0_data / i_m1_data  in  32  store data (unaligned, low bits significant)
- i_m0_funct3 / i_m1_funct3  in  3  000 SB, 001 SH, 010 SW
- o_io_wren  out  1  write pulse to output buffer
- o_io_addr  out  32  registered address
- o_io_st_data  out  32  registered data
- o_io_funct3  out  3  registered funct3
- o_grant_id  out  1  requester that produced the current o_io_* values
- o_err  out  1  one-cycle pulse: accepted request was dropped
- o_err_id  out  1  requester of the dropped request
- o_err_cnt  out  8  saturating dropped-request count

## Operation
- Reset values: all o_io_* = 0, o_grant_id = 0, o_err = 0, o_err_id = 0, o_err_cnt = 0. Internal last_grant = 1, so requester 0 wins first under round-robin. starve_cnt = 0.
- Readies are combinational from the valids and internal state. At most one ready is high per cycle. Ready is never high without the matching valid.
- Only one valid: that requester is granted.
- Both valid, M0_PRIO=0: grant the requester not equal to last_grant. last_grant updates on every transfer.
- Both valid, M0_PRIO=1: grant requester 0 unless starve_cnt == STARVE_LIMIT, in which case grant requester 1.
- starve_cnt (M0_PRIO=1):
  - increments, saturating at STARVE_LIMIT, when i_m1_valid & ~o_m1_ready;
  - clears when requester 1 transfers or i_m1_valid is low.
- Requesters hold valid, addr, data and funct3 stable until ready. Valid may not drop before ready.
- On a transfer, addr, data, funct3 and id are captured into the output registers, and o_io_wren = 1 the next cycle.
- With no transfer, o_io_wren = 0 and the output registers hold their last values.
- Back-to-back transfers give o_io_wren high for consecutive cycles. Throughput is 1 store per cycle.
- No buffering beyond the output register. The downstream buffer always accepts.
- Reset asserted mid-operation: all state and outputs return to reset values immediately. An in-flight pulse is lost.

## Timing
- Grant: same cycle as valid (0-cycle arbitration).
- Write latency: o_io_wren is asserted on the first rising edge after the transfer cycle. The buffer updates one edge later.
- o_err and o_err_cnt update on the same edge as o_io_wren would have.
- Fixed-priority worst-case requester-1 wait: STARVE_LIMIT cycles. Round-robin worst-case wait: 1 cycle.

## Configuration
- IO_ARB_ADDR_CHECK_EN defined: a transfer is still completed (ready asserted, request consumed), but o_io_wren stays 0 if any of these hold:
  - addr[31:16] != 16'h1000;
  - addr[15:12] > 4;
  - funct3 is not 000, 001 or 010.
  
  In that case o_err pulses for 1 cycle, o_err_id = requester, and o_err_cnt increments, saturating at 255. The output registers keep their previous contents.
- IO_ARB_ADDR_CHECK_EN undefined: all transfers are forwarded. o_err, o_err_id and o_err_cnt are tied 0. The ports remain present.

## Test plan
- Reset then a single m0 SW to 0x1000_1000 with data 0xDEADBEEF:
  - o_m0_ready = 1 in the same cycle;
  - next cycle o_io_wren = 1, o_io_addr = 0x1000_1000, o_io_st_data = 0xDEADBEEF, o_grant_id = 0.
- M0_PRIO=0, both valid for 6 cycles: grants alternate 0,1,0,1,0,1 and o_io_wren stays high for 6 consecutive cycles.
- M0_PRIO=1, STARVE_LIMIT=4, both valid continuously:
  - grants are 0,0,0,0,1 and the pattern repeats;
  - starve_cnt reaches 4 before each requester-1 grant.
- Reset asserted on the cycle after a transfer: o_io_wren, o_io_addr and o_err_cnt read 0 while in reset, and no write pulse appears after release.
- IO_ARB_ADDR_CHECK_EN defined:
  - m1 SB to 0x2000_0000: o_m1_ready = 1, o_io_wren = 0, o_err = 1, o_err_id = 1, o_err_cnt = 1;
  - m1 funct3 = 011 to 0x1000_2000: dropped, o_err_cnt = 2;
  - 300 bad stores: o_err_cnt saturates at 255.
- IO_ARB_ADDR_CHECK_EN undefined: same store to 0x2000_0000 produces o_io_wren = 1 and o_err = 0.
